// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline stage register with a valid/ready handshake.
//
// SKID = 0: one data register; in_ready is a combinational pass-through of out_ready.
// SKID = 1: main plus skid register. in_ready comes from state flops only, so the
//           ready path does not chain combinationally across stages.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset, clears all state
//   flush      synchronous kill of all held entries; blocks input for the cycle
//   in_valid   upstream has data
//   in_ready   stage accepts data this cycle
//   in_data    upstream payload, sampled only on input fire
//   out_valid  out_data is valid
//   out_ready  downstream accepts this cycle
//   out_data   payload, always the main register
//   occupancy  number of held entries (0..2, max 1 when SKID = 0)
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 64,
  parameter int unsigned      SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  if (SKID != 0) begin : g_skid
    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= StEmpty;
        main_q  <= RESET_VAL;
        skid_q  <= RESET_VAL;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
      end
    end

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = StEmpty;
        main_d  = RESET_VAL;
        skid_d  = RESET_VAL;
      end else begin
        case (state_q)
          StEmpty: begin
            if (in_fire) begin
              state_d = StOne;
              main_d  = in_data;
            end
          end
          StOne: begin
            if (in_fire && out_fire) begin
              main_d = in_data;
            end else if (in_fire) begin
              state_d = StFull;
              skid_d  = in_data;
            end else if (out_fire) begin
              state_d = StEmpty;
            end
          end
          StFull: begin
            // in_ready is low here, so only a drain can happen.
            if (out_fire) begin
              state_d = StOne;
              main_d  = skid_q;
            end
          end
          default: state_d = StEmpty;
        endcase
      end
    end

    always_comb begin
      in_ready  = ~flush & (state_q != StFull);
      out_valid = (state_q != StEmpty);
      occupancy = state_q;
      out_data  = main_q;
    end
  end else begin : g_pass
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] main_q, main_d;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        valid_q <= 1'b0;
        main_q  <= RESET_VAL;
      end else begin
        valid_q <= valid_d;
        main_q  <= main_d;
      end
    end

    always_comb begin
      valid_d = valid_q;
      main_d  = main_q;
      if (flush) begin
        valid_d = 1'b0;
        main_d  = RESET_VAL;
      end else if (in_fire) begin
        valid_d = 1'b1;
        main_d  = in_data;
      end else if (out_fire) begin
        valid_d = 1'b0;
      end
    end

    always_comb begin
      in_ready  = ~flush & (~valid_q | out_ready);
      out_valid = valid_q;
      occupancy = {1'b0, valid_q};
      out_data  = main_q;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one skid-mode and one pass-through instance share the
// stimulus. A queue per instance models the held entries; the compare process checks
// every cycle, and directed sections pin literal values.
module tb_pipe_stage_reg;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         s_in_ready, s_out_valid;
  logic [W-1:0] s_out_data;
  logic [1:0]   s_occ;
  logic         p_in_ready, p_out_valid;
  logic [W-1:0] p_out_data;
  logic [1:0]   p_occ;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] qs[$];
  logic [W-1:0] qp[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .SKID(1)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .in_data   (in_data),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_data  (s_out_data),
    .occupancy (s_occ)
  );

  pipe_stage_reg #(.WIDTH(W), .SKID(0)) u_pass (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (p_in_ready),
    .in_data   (in_data),
    .out_valid (p_out_valid),
    .out_ready (out_ready),
    .out_data  (p_out_data),
    .occupancy (p_occ)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a skid stage holds up to two entries and accepts whenever not full; a
  // pass-through stage holds one and accepts when empty or draining this cycle.
  always @(negedge clk) begin
    logic exp_s_ir, exp_p_ir, s_in_f, s_out_f, p_in_f, p_out_f;
    if (!reset) begin
      qs.delete();
      qp.delete();
    end
    exp_s_ir = !flush && (qs.size() < 2);
    exp_p_ir = !flush && ((qp.size() == 0) || out_ready);
    chk("skid in_ready", 32'(s_in_ready), 32'(exp_s_ir));
    chk("skid out_valid", 32'(s_out_valid), 32'(qs.size() > 0));
    chk("skid occupancy", 32'(s_occ), 32'(qs.size()));
    if (qs.size() > 0) chk("skid out_data", 32'(s_out_data), 32'(qs[0]));
    chk("pass in_ready", 32'(p_in_ready), 32'(exp_p_ir));
    chk("pass out_valid", 32'(p_out_valid), 32'(qp.size() > 0));
    chk("pass occupancy", 32'(p_occ), 32'(qp.size()));
    if (qp.size() > 0) chk("pass out_data", 32'(p_out_data), 32'(qp[0]));
    if (reset) begin
      s_in_f  = in_valid && exp_s_ir;
      s_out_f = (qs.size() > 0) && out_ready;
      p_in_f  = in_valid && exp_p_ir;
      p_out_f = (qp.size() > 0) && out_ready;
      if (flush) begin
        qs.delete();
        qp.delete();
      end else begin
        if (s_out_f) void'(qs.pop_front());
        if (s_in_f) qs.push_back(in_data);
        if (p_out_f) void'(qp.pop_front());
        if (p_in_f) qp.push_back(in_data);
      end
    end
  end

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("reset out_valid", 32'(s_out_valid), 32'd0);
    chk("reset out_data", 32'(s_out_data), 32'd0);
    chk("reset occupancy", 32'(s_occ), 32'd0);
    chk("reset in_ready", 32'(s_in_ready), 32'd1);
    chk("reset pass in_ready", 32'(p_in_ready), 32'd1);

    // Stream 1,2,3 with out_ready high: each appears one cycle after its input.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = W'(i);
      step();
      chk("stream skid data", 32'(s_out_data), 32'(i));
      chk("stream skid valid", 32'(s_out_valid), 32'd1);
      chk("stream pass data", 32'(p_out_data), 32'(i));
    end
    in_valid = 1'b0;
    step();
    chk("stream drained", 32'(s_out_valid), 32'd0);

    // Skid fill then drain.
    in_valid = 1'b1;
    in_data  = 8'h0A;
    step();
    in_data   = 8'h0B;
    out_ready = 1'b0;
    #1;
    chk("pass in_ready stalled", 32'(p_in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    #1;
    chk("fill occupancy", 32'(s_occ), 32'd2);
    chk("fill in_ready", 32'(s_in_ready), 32'd0);
    chk("fill head", 32'(s_out_data), 32'h0A);
    out_ready = 1'b1;
    step();
    chk("drain second", 32'(s_out_data), 32'h0B);
    chk("drain in_ready back", 32'(s_in_ready), 32'd1);
    step();
    chk("drain empty", 32'(s_out_valid), 32'd0);

    // Fill again, then flush while FULL with 0xC offered.
    in_valid  = 1'b1;
    in_data   = 8'h0A;
    step();
    in_data   = 8'h0B;
    out_ready = 1'b0;
    step();
    in_data = 8'h0C;
    flush   = 1'b1;
    #1;
    chk("flush blocks in_ready", 32'(s_in_ready), 32'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush out_valid", 32'(s_out_valid), 32'd0);
    chk("flush occupancy", 32'(s_occ), 32'd0);
    chk("flush out_data", 32'(s_out_data), 32'd0);

    // Mode 0 pass-through with no bubble.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h54;
    step();
    in_data = 8'h55;
    #1;
    chk("pass ready through", 32'(p_in_ready), 32'd1);
    step();
    chk("pass no bubble data", 32'(p_out_data), 32'h55);
    chk("pass no bubble valid", 32'(p_out_valid), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("pass ready blocked", 32'(p_in_ready), 32'd0);

    // Async reset between edges while the skid instance is FULL.
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    step();
    in_data = 8'h22;
    step();
    in_valid = 1'b0;
    chk("pre-reset full", 32'(s_occ), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("async reset out_valid", 32'(s_out_valid), 32'd0);
    chk("async reset occupancy", 32'(s_occ), 32'd0);
    chk("async reset pass valid", 32'(p_out_valid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Random soak.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(1, 0));
      out_ready = 1'($urandom_range(1, 0));
      flush     = ($urandom_range(99, 0) < 5);
      in_data   = W'($urandom);
      step();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
